// File: rtl/bram_arbiter_if.sv
// Bus bundle between CPU mem stage, accelerator load/store port and the shared data BRAM.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface bram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();
  logic              cpu_en;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;

  logic              acc_req;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_gnt;
  logic              acc_rvalid;
  logic [DATA_W-1:0] acc_rdata;

  logic              bram_en;
  logic              bram_wr;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata;

  modport slave (
    input  cpu_en, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  acc_req, acc_wr, acc_addr, acc_wdata,
    output acc_gnt, acc_rvalid, acc_rdata,
    output bram_en, bram_wr, bram_addr, bram_wdata,
    input  bram_rdata
  );

  modport master (
    output cpu_en, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output acc_req, acc_wr, acc_addr, acc_wdata,
    input  acc_gnt, acc_rvalid, acc_rdata,
    input  bram_en, bram_wr, bram_addr, bram_wdata,
    output bram_rdata
  );
endinterface

// File: rtl/bram_arbiter.sv
// CPU-priority arbiter for the single-port data BRAM; a saturating wait counter forces
// a bounded accelerator burst so the accelerator cannot starve.
module bram_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ACC_MAX_WAIT = 4,
  parameter int unsigned ACC_BURST    = 4
) (
  input logic           clk,
  input logic           rst,
  bram_arbiter_if.slave bus
);
  localparam int unsigned WaitW  = $clog2(ACC_MAX_WAIT + 1);
  localparam int unsigned BurstW = $clog2(ACC_BURST + 1);
  localparam logic [WaitW-1:0]  WaitMax  = WaitW'(ACC_MAX_WAIT);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(ACC_BURST);

  typedef enum logic [0:0] {StCpuPri, StAccBurst} state_e;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic              acc_rd_q, acc_rd_d;
  logic              cpu_grant, acc_grant;
  logic [BurstW-1:0] burst_inc;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  assign burst_inc = burst_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StCpuPri;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
      cpu_rd_q    <= 1'b0;
      acc_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      cpu_rd_q    <= cpu_rd_d;
      acc_rd_q    <= acc_rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    cpu_grant   = 1'b0;
    acc_grant   = 1'b0;
    // Grants are masked while reset is held so the BRAM never sees an access then.
    if (!rst) begin
      unique case (state_q)
        StCpuPri: begin
          if (bus.acc_req && (!bus.cpu_en || wait_cnt_q == WaitMax)) begin
            acc_grant = 1'b1;
            if (bus.cpu_en && ACC_BURST > 1) begin
              state_d     = StAccBurst;
              burst_cnt_d = BurstW'(1);
            end
          end else if (bus.cpu_en) begin
            cpu_grant = 1'b1;
          end
        end
        StAccBurst: begin
          if (bus.acc_req) begin
            acc_grant   = 1'b1;
            burst_cnt_d = burst_inc;
            if (burst_inc == BurstMax) begin
              state_d     = StCpuPri;
              burst_cnt_d = '0;
            end
          end else begin
            // Accelerator walked away early: hand the cycle straight back to the CPU.
            cpu_grant   = bus.cpu_en;
            state_d     = StCpuPri;
            burst_cnt_d = '0;
          end
        end
        default: state_d = StCpuPri;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.acc_req || acc_grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WaitMax) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  assign cpu_rd_d = cpu_grant && !bus.cpu_wr;
  assign acc_rd_d = acc_grant && !bus.acc_wr;

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (acc_grant) begin
      addr_mux  = bus.acc_addr;
      wdata_mux = bus.acc_wdata;
    end else if (cpu_grant) begin
      addr_mux  = bus.cpu_addr;
      wdata_mux = bus.cpu_wdata;
    end
  end

  assign bus.bram_en    = cpu_grant | acc_grant;
  assign bus.bram_wr    = (acc_grant & bus.acc_wr) | (cpu_grant & bus.cpu_wr);
  assign bus.bram_addr  = addr_mux;
  assign bus.bram_wdata = wdata_mux;

  assign bus.cpu_stall  = bus.cpu_en && !cpu_grant && !rst;
  assign bus.acc_gnt    = acc_grant;
  assign bus.cpu_rdata  = cpu_rd_q ? bus.bram_rdata : '0;
  assign bus.acc_rvalid = acc_rd_q;
  assign bus.acc_rdata  = acc_rd_q ? bus.bram_rdata : '0;
endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: a vector table for single-cycle behaviour plus
// hand-written starvation, early-exit and async-reset sequences. Includes a BRAM model.
module tb_bram_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  bram_arbiter #(
    .ADDR_W(16), .DATA_W(16), .ACC_MAX_WAIT(4), .ACC_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Synchronous single-port BRAM, 1-cycle read latency.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      bus.bram_rdata <= 16'h0;
    end else if (bus.bram_en) begin
      if (bus.bram_wr) mem[bus.bram_addr[7:0]] <= bus.bram_wdata;
      else             bus.bram_rdata <= mem[bus.bram_addr[7:0]];
    end
  end

  typedef struct {
    logic        cpu_en;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        acc_req;
    logic        acc_wr;
    logic [15:0] acc_addr;
    logic [15:0] acc_wdata;
    logic        e_stall;
    logic        e_gnt;
    logic        e_en;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_rvalid;
    logic [15:0] e_cpu_rdata;
    logic [15:0] e_acc_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ce, input logic cw, input logic [15:0] ca,
                       input logic [15:0] cd, input logic ar, input logic aw,
                       input logic [15:0] aa, input logic [15:0] ad);
    bus.cpu_en    = ce;
    bus.cpu_wr    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.acc_req   = ar;
    bus.acc_wr    = aw;
    bus.acc_addr  = aa;
    bus.acc_wdata = ad;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // One continuous-CPU-read cycle with the accelerator reading 0x0020 when ar=1.
  task automatic starve_cycle(input logic ar);
    drive(1'b1, 1'b0, 16'h0010, 16'h0, ar, 1'b0, 16'h0020, 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000,
                 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hBEEF, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234,
                 1'b0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000,
                 1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h1234};
    vecs[7]  = '{1'b1, 1'b1, 16'h0030, 16'h5555, 1'b0, 1'b0, 16'h0000, 16'h0000,
                 1'b0, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h5555, 1'b0, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000,
                 1'b0, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000,
                 1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h5555, 16'h0000};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h1234};

    // Outputs while reset is held.
    repeat (2) @(negedge clk);
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);
    #1;
    chk("rst_gnt", 16'(bus.acc_gnt), 16'h0);
    chk("rst_stall", 16'(bus.cpu_stall), 16'h0);
    chk("rst_bram_en", 16'(bus.bram_en), 16'h0);
    chk("rst_bram_addr", bus.bram_addr, 16'h0);
    chk("rst_rvalid", 16'(bus.acc_rvalid), 16'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].cpu_en, vecs[i].cpu_wr, vecs[i].cpu_addr, vecs[i].cpu_wdata,
            vecs[i].acc_req, vecs[i].acc_wr, vecs[i].acc_addr, vecs[i].acc_wdata);
      #1;
      chk($sformatf("v%0d_stall", i), 16'(bus.cpu_stall), 16'(vecs[i].e_stall));
      chk($sformatf("v%0d_gnt", i), 16'(bus.acc_gnt), 16'(vecs[i].e_gnt));
      chk($sformatf("v%0d_bram_en", i), 16'(bus.bram_en), 16'(vecs[i].e_en));
      chk($sformatf("v%0d_bram_wr", i), 16'(bus.bram_wr), 16'(vecs[i].e_wr));
      chk($sformatf("v%0d_bram_addr", i), bus.bram_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_bram_wdata", i), bus.bram_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_rvalid", i), 16'(bus.acc_rvalid), 16'(vecs[i].e_rvalid));
      chk($sformatf("v%0d_cpu_rdata", i), bus.cpu_rdata, vecs[i].e_cpu_rdata);
      chk($sformatf("v%0d_acc_rdata", i), bus.acc_rdata, vecs[i].e_acc_rdata);
    end

    // Starvation: CPU reads every cycle, accelerator requests cycles 0..7.
    for (int c = 0; c < 10; c++) begin
      logic g;
      logic rv;
      logic cr;
      @(negedge clk);
      starve_cycle(c <= 7);
      #1;
      g  = (c >= 4 && c <= 7);
      rv = (c >= 5 && c <= 8);
      cr = (c >= 1 && c <= 4) || c == 9;
      chk($sformatf("starve%0d_gnt", c), 16'(bus.acc_gnt), 16'(g));
      chk($sformatf("starve%0d_stall", c), 16'(bus.cpu_stall), 16'(g));
      chk($sformatf("starve%0d_addr", c), bus.bram_addr, g ? 16'h0020 : 16'h0010);
      chk($sformatf("starve%0d_rvalid", c), 16'(bus.acc_rvalid), 16'(rv));
      chk($sformatf("starve%0d_acc_rdata", c), bus.acc_rdata, rv ? 16'h1234 : 16'h0);
      chk($sformatf("starve%0d_cpu_rdata", c), bus.cpu_rdata, cr ? 16'hBEEF : 16'h0);
    end

    // Early burst exit: forced at cycle 4, two grants, request dropped at cycle 6.
    for (int c = 0; c < 8; c++) begin
      logic g;
      @(negedge clk);
      starve_cycle(c != 6);
      #1;
      g = (c == 4 || c == 5);
      chk($sformatf("early%0d_gnt", c), 16'(bus.acc_gnt), 16'(g));
      chk($sformatf("early%0d_stall", c), 16'(bus.cpu_stall), 16'(g));
      chk($sformatf("early%0d_addr", c), bus.bram_addr, g ? 16'h0020 : 16'h0010);
      chk($sformatf("early%0d_rvalid", c), 16'(bus.acc_rvalid), 16'(c == 5 || c == 6));
    end
    @(negedge clk);
    idle();

    // Async reset during cycle 5 of a starvation episode.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      starve_cycle(1'b1);
    end
    #1;
    chk("prerst_gnt", 16'(bus.acc_gnt), 16'h1);
    chk("prerst_rvalid", 16'(bus.acc_rvalid), 16'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 16'(bus.acc_gnt), 16'h0);
    chk("midrst_stall", 16'(bus.cpu_stall), 16'h0);
    chk("midrst_bram_en", 16'(bus.bram_en), 16'h0);
    chk("midrst_bram_addr", bus.bram_addr, 16'h0);
    chk("midrst_rvalid", 16'(bus.acc_rvalid), 16'h0);
    chk("midrst_acc_rdata", bus.acc_rdata, 16'h0);
    chk("midrst_cpu_rdata", bus.cpu_rdata, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("postrst_stall", 16'(bus.cpu_stall), 16'h0);
    chk("postrst_bram_en", 16'(bus.bram_en), 16'h1);
    chk("postrst_addr", bus.bram_addr, 16'h0010);
    chk("postrst_rvalid0", 16'(bus.acc_rvalid), 16'h0);
    @(negedge clk);
    #1;
    chk("postrst_rvalid1", 16'(bus.acc_rvalid), 16'h0);
    chk("postrst_cpu_rdata", bus.cpu_rdata, 16'hBEEF);
    @(negedge clk);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Arbiter that shares the single-port data BRAM between the CPU memory stage and the accelerator load/store port. The CPU has priority. A saturating wait counter guarantees the accelerator access after `ACC_MAX_WAIT` denied cycles, then grants it a bounded burst. The block sits between the CPU mem/wb data-memory signals, the accelerator bus master and the BRAM. BRAM read latency is 1 cycle.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `ACC_MAX_WAIT`, 4, consecutive denied accelerator cycles before a forced grant (≥1)
- `ACC_BURST`, 4, max consecutive accelerator grants once forced (≥1)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset is asynchronous and active-high
- `cpu_en` in 1: CPU access request, held stable while `cpu_stall`=1
- `cpu_wr` in 1: 1=write, 0=read
- `cpu_addr` in ADDR_W; `cpu_wdata` in DATA_W
- `cpu_stall` out 1: `cpu_en` asserted but not granted this cycle
- `cpu_rdata` out DATA_W: read data, cycle after CPU read grant
- `acc_req` in 1: accelerator request, held until `acc_gnt`
- `acc_wr` in 1; `acc_addr` in ADDR_W; `acc_wdata` in DATA_W
- `acc_gnt` out 1: request accepted this cycle
- `acc_rvalid` out 1: `acc_rdata` valid
- `acc_rdata` out DATA_W
- `bram_en` out 1; `bram_wr` out 1; `bram_addr` out ADDR_W; `bram_wdata` out DATA_W
- `bram_rdata` in DATA_W: synchronous BRAM output

## Operation
- **FSM states:** `CPU_PRI` (reset state) and `ACC_BURST`.
- **`CPU_PRI` grant** (combinational):
  - Accelerator wins if `acc_req && (!cpu_en || wait_cnt==ACC_MAX_WAIT)`.
  - Otherwise CPU wins if `cpu_en`.
  - Otherwise no grant.
- **Forced grant:** an accelerator grant with `cpu_en`=1 is forced. It moves to `ACC_BURST` with `burst_cnt`=1, unless `ACC_BURST`=1, in which case the FSM stays in `CPU_PRI`.
- **`ACC_BURST` grant:**
  - If `acc_req`, accelerator granted and `burst_cnt`++.
  - Exit to `CPU_PRI` when the granted `burst_cnt` reaches `ACC_BURST`.
  - If `acc_req`=0, the cycle is arbitrated by `CPU_PRI` rules, with the CPU granted if `cpu_en`, and the FSM returns to `CPU_PRI` at the next edge.
- **`wait_cnt`:**
  - Increments (saturating at `ACC_MAX_WAIT`) when `acc_req && !acc_gnt`.
  - Clears on `acc_gnt` or `!acc_req`.
- **BRAM mux** (combinational from grant):
  - `bram_en` = any grant.
  - `bram_wr`/`bram_addr`/`bram_wdata` come from the winner.
  - All zero when no grant.
- **Read return:**
  - Registered flags `cpu_rd_q`/`acc_rd_q` = read granted last cycle.
  - `cpu_rdata` = `bram_rdata` when `cpu_rd_q`, else 0.
  - `acc_rvalid` = `acc_rd_q`; `acc_rdata` = `bram_rdata` when `acc_rd_q`, else 0.
- **Writes** complete in the grant cycle; no response.
- **`cpu_stall`** = `cpu_en && !cpu_grant`.
- **`acc_gnt`** = accelerator grant.

## Timing
- **Reset:**
  - While `rst`=1: state=`CPU_PRI`, `wait_cnt`=0, `burst_cnt`=0, `cpu_rd_q`=`acc_rd_q`=0.
  - All grants forced 0: `acc_gnt`=0, `cpu_stall`=0, `bram_*`=0, `acc_rvalid`=0, rdata outputs=0.
- **Reset mid-burst or mid-read:** pending `rvalid` is dropped and the FSM returns to `CPU_PRI`. No spurious `acc_rvalid` after deassertion.
- **Grant latency:**
  - CPU: 0 cycles when no forced or burst accelerator access.
  - Accelerator with CPU idle: 0 cycles.
  - Accelerator under continuous CPU traffic: granted on cycle `ACC_MAX_WAIT` after first request (cycles 0..`ACC_MAX_WAIT`-1 denied).
- **Read latency:** data and `acc_rvalid` appear exactly 1 cycle after the grant cycle.
- **Simultaneous requests:**
  - Exactly one grant per cycle. `bram_en` never reflects two sources.
  - If both request in the same cycle and `wait_cnt`<`ACC_MAX_WAIT`, the CPU wins.
- **Back-to-back accelerator reads:** one per cycle in `ACC_BURST`; `acc_rvalid` stays high continuously.
- **CPU stall bound:** ≤ `ACC_BURST` cycles per forced episode.
- **Counters:** `wait_cnt` width is clog2(`ACC_MAX_WAIT`+1), saturating. `burst_cnt` width is clog2(`ACC_BURST`+1).

## Test plan
- **CPU only:** `cpu_en`=1, `cpu_wr`=0, `cpu_addr`=0x0010, with the BRAM holding 0xBEEF there → `bram_en`=1, `bram_addr`=0x0010 same cycle; `cpu_rdata`=0xBEEF next cycle; `cpu_stall`=0 throughout.
- **Accelerator only:** write 0x1234 to 0x0020 (`acc_gnt` same cycle), then read 0x0020 → `acc_rvalid`=1 with `acc_rdata`=0x1234 one cycle after the read grant.
- **Starvation (defaults):** `cpu_en` held 1 continuously, `acc_req` raised at cycle 0 →
  - Cycles 0–3: CPU granted, `acc_gnt`=0.
  - Cycles 4–7: `acc_gnt`=1 (4 reads) and `cpu_stall`=1.
  - Cycle 8: CPU granted again.
  - `acc_rvalid` high cycles 5–8.
- **Early burst exit:** in `ACC_BURST`, `acc_req` dropped after 2 grants → the CPU is granted in that same cycle, `cpu_stall`=0, and state=`CPU_PRI` at the next edge.
- **Async reset mid-burst:** assert `rst` between clock edges during cycle 5 of the starvation test → all outputs 0 immediately; after release with only `cpu_en`=1, the CPU is granted with no `acc_rvalid` pulse.
